// File: rtl/spart_pkg.sv
// Shared constants, state encodings and the baud-select decode for the
// mini-SPART loopback design.
package spart_pkg;

    localparam logic [15:0] DIV_4800  = 16'h12C0;
    localparam logic [15:0] DIV_9600  = 16'h0960;
    localparam logic [15:0] DIV_19200 = 16'h04B0;
    localparam logic [15:0] DIV_38400 = 16'h0258;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_PT  = 8;

    // Tick counters compare against the index of the Nth tick, hence the -1.
    localparam logic [3:0] TICK_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_SAMPLE = 4'(SAMPLE_PT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SEND
    } tx_state_e;

    typedef enum logic [1:0] {
        DRV_PROG_LO,
        DRV_PROG_HI,
        DRV_IDLE,
        DRV_ECHO
    } drv_state_e;

    function automatic logic [15:0] cfg_divisor(input logic [1:0] cfg);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Programmable 16x oversampling tick generator: en pulses once every
// `divisor` clocks; a byte write to either half restarts the count.
module baud_rate_gen
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       sel_low,
    input  logic       sel_high,
    output logic       en
);

    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] reload;
    logic        wr_q;

    // Divisors of 0 and 1 both collapse to a tick every cycle.
    assign reload = (div_q <= 16'd1) ? 16'd0 : div_q - 16'd1;
    assign en     = (cnt_q == 16'd0) && !wr_q;

    always_comb begin
        div_d = div_q;
        if (sel_low)  div_d[7:0]  = data;
        if (sel_high) div_d[15:8] = data;
    end

    always_comb begin
        cnt_d = cnt_q - 16'd1;
        if (wr_q || cnt_q == 16'd0) cnt_d = reload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_4800;
            cnt_q <= DIV_4800 - 16'd1;
            wr_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            wr_q  <= sel_low | sel_high;
        end
    end

endmodule

// File: rtl/rx.sv
// 8N1 receiver with 16x oversampling; centre-samples each bit and holds the
// last good byte with RDA until the consumer acknowledges with rd_rx.
module rx
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       Baud,
    input  logic       rd_rx,
    output logic [7:0] RxD_data,
    output logic       RDA
);

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rx_sync_q;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rda_q, rda_d;
    logic       ferr_q, ferr_d;
    logic       done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RxD;
            rx_sync_q <= rx_meta_q;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rda_q     <= rda_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    tick_d  = '0;
                end
            end
            RX_START: begin
                if (Baud) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_SAMPLE) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (Baud) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // A low stop bit parks here until the line recovers.
                if (ferr_q) begin
                    if (rx_sync_q) begin
                        ferr_d  = 1'b0;
                        state_d = RX_IDLE;
                    end
                end else if (Baud) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        if (rx_sync_q) begin
                            done    = 1'b1;
                            data_d  = shift_q;
                            state_d = RX_IDLE;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        rda_d = done ? 1'b1 : (rd_rx ? 1'b0 : rda_q);
    end

    always_comb begin
        RxD_data = data_q;
        RDA      = rda_q;
    end

endmodule

// File: rtl/tx.sv
// 8N1 transmitter: a byte accepted while idle goes out starting at the next
// baud tick, 16 ticks per bit, and tbr reports ready again after the stop bit.
module tx
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       en,
    input  logic       en_tx,
    output logic       tbr,
    output logic       TxD
);

    tx_state_e  state_q, state_d;
    logic [9:0] shift_q, shift_d;
    logic [3:0] tick_q, tick_d;
    logic [3:0] bit_q, bit_d;
    logic       txd_q, txd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shift_q <= '1;
            tick_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        unique case (state_q)
            TX_IDLE: begin
                if (en_tx) begin
                    shift_d = {1'b1, data, 1'b0};
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (en) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[9:1]};
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (en) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        // bit 9 is the stop bit; its last tick frees the line.
                        if (bit_q == 4'd9) begin
                            txd_d   = 1'b1;
                            state_d = TX_IDLE;
                        end else begin
                            txd_d   = shift_q[0];
                            shift_d = {1'b1, shift_q[9:1]};
                            bit_d   = bit_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tbr = (state_q == TX_IDLE);
        TxD = txd_q;
    end

endmodule

// File: rtl/spart_echo_top.sv
// Loopback top: programs the baud divisor from br_cfg, then echoes every
// correctly framed received byte back out on txd.
module spart_echo_top
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       txd,
    input  logic       rxd,
    input  logic [1:0] br_cfg
);

    logic        en, tbr, RDA, rd_rx, en_tx, sel_low, sel_high;
    logic [7:0]  RxD_data, brg_data;
    logic [15:0] div_w;
    drv_state_e  drv_state_q, drv_state_d;
    logic [1:0]  cfg_q, cfg_d;

    baud_rate_gen u_brg (
        .clk      (clk),
        .rst      (rst),
        .data     (brg_data),
        .sel_low  (sel_low),
        .sel_high (sel_high),
        .en       (en)
    );

    rx u_rx (
        .clk      (clk),
        .rst      (rst),
        .RxD      (rxd),
        .Baud     (en),
        .rd_rx    (rd_rx),
        .RxD_data (RxD_data),
        .RDA      (RDA)
    );

    tx u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (RxD_data),
        .en    (en),
        .en_tx (en_tx),
        .tbr   (tbr),
        .TxD   (txd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_state_q <= DRV_PROG_LO;
            cfg_q       <= 2'b00;
        end else begin
            drv_state_q <= drv_state_d;
            cfg_q       <= cfg_d;
        end
    end

    always_comb begin
        drv_state_d = drv_state_q;
        cfg_d       = cfg_q;
        unique case (drv_state_q)
            DRV_PROG_LO: begin
                cfg_d       = br_cfg;
                drv_state_d = DRV_PROG_HI;
            end
            DRV_PROG_HI: drv_state_d = DRV_IDLE;
            DRV_IDLE: begin
                if (br_cfg != cfg_q)   drv_state_d = DRV_PROG_LO;
                else if (RDA && tbr)   drv_state_d = DRV_ECHO;
            end
            default: drv_state_d = DRV_IDLE;
        endcase
    end

    // The low byte is taken from the live switches; the high byte from the
    // value latched while writing the low byte, so both halves always match.
    always_comb begin
        sel_low  = 1'b0;
        sel_high = 1'b0;
        rd_rx    = 1'b0;
        en_tx    = 1'b0;
        div_w    = cfg_divisor((drv_state_q == DRV_PROG_LO) ? br_cfg : cfg_q);
        brg_data = div_w[7:0];
        unique case (drv_state_q)
            DRV_PROG_LO: sel_low = 1'b1;
            DRV_PROG_HI: begin
                sel_high = 1'b1;
                brg_data = div_w[15:8];
            end
            DRV_IDLE: begin
                if (br_cfg == cfg_q && RDA && tbr) begin
                    rd_rx = 1'b1;
                    en_tx = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spart_echo_top.sv
// Loopback bench: an 8N1 sender drives rxd and a queue-fed monitor decodes
// txd frames. Echo traffic runs with the divisor pinned small to keep frames short.
module tb_spart_echo_top;
    import spart_pkg::*;

    localparam int FDIV = 8;
    localparam int BIT  = 16 * FDIV;

    logic       clk = 1'b0;
    logic       rst, rxd, txd;
    logic [1:0] br_cfg;
    int         checks = 0;
    int         errors = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spart_echo_top dut (
        .clk    (clk),
        .rst    (rst),
        .txd    (txd),
        .rxd    (rxd),
        .br_cfg (br_cfg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic measure_period(output int p);
        int w;
        w = 0;
        while (dut.en !== 1'b1 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        p = 0;
        do begin
            @(negedge clk);
            p++;
        end while (dut.en !== 1'b1 && p < 20000);
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int w;
        w = 0;
        while (frames_seen < target && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(name, frames_seen, target);
    endtask

    task automatic mon_wait(input int n, output bit abort);
        abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
        end
    endtask

    // Monitor: decodes txd at bit centres; frames cut short by reset are dropped.
    initial begin : monitor
        logic [7:0] b;
        logic       sb;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                b  = '0;
                sb = 1'b0;
                mon_wait(BIT / 2 - 1, ab);
                for (int i = 0; i < 8 && !ab; i++) begin
                    mon_wait(BIT, ab);
                    b[i] = txd;
                end
                if (!ab) begin
                    mon_wait(BIT, ab);
                    sb = txd;
                end
                if (!ab) begin
                    frames_seen++;
                    check("stop_bit", sb, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h required=none", b);
                    end else begin
                        check("echo_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  p;
        int  seen;
        bit  quiet_ok;
        rst    = 1'b1;
        rxd    = 1'b1;
        br_cfg = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tbr", dut.tbr, 1);
        check("rst_rda", dut.RDA, 0);
        check("rst_rxdata", dut.RxD_data, 0);
        check("rst_en", dut.en, 0);
        check("rst_drv_state", dut.drv_state_q, DRV_PROG_LO);
        rst = 1'b0;

        // Baud select with the real divisors
        repeat (5) @(negedge clk);
        check("div_reg_00", dut.u_brg.div_q, 16'h12C0);
        measure_period(p);
        check("period_00", p, 4800);
        br_cfg = 2'b11;
        repeat (5) @(negedge clk);
        check("div_reg_11", dut.u_brg.div_q, 16'h0258);
        measure_period(p);
        check("period_11", p, 600);
        br_cfg = 2'b01;
        repeat (5) @(negedge clk);
        check("div_reg_01", dut.u_brg.div_q, 16'h0960);
        measure_period(p);
        check("period_01", p, 2400);

        force dut.u_brg.div_q = 16'(FDIV);
        repeat (3000) @(negedge clk);

        // Basic echo
        exp_q.push_back(8'h40);
        send_byte(8'h40, 1'b1);
        wait_frames("basic_frames", 1, 4000);

        // Back-to-back data patterns
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA5);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_frames("pattern_frames", 4, 6000);

        // Glitch: 5 ticks low
        rxd = 1'b0;
        repeat (5 * FDIV) @(negedge clk);
        rxd = 1'b1;
        repeat (2000) @(negedge clk);
        check("glitch_frames", frames_seen, 4);
        check("glitch_rda", dut.RDA, 0);

        // Framing error, then a good byte
        send_byte(8'hC3, 1'b0);
        repeat (2500) @(negedge clk);
        check("ferr_frames", frames_seen, 4);
        check("ferr_rda", dut.RDA, 0);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_frames("after_ferr_frames", 5, 4000);

        // Reset during data bit 3 of an echo; that frame is never expected
        fork
            send_byte(8'hF0, 1'b1);
        join_none
        p = 0;
        while (txd !== 1'b0 && p < 3000) begin
            @(negedge clk);
            p++;
        end
        check("reset_echo_started", txd, 0);
        repeat (BIT / 2 + 4 * BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_tbr", dut.tbr, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen     = frames_seen;
        quiet_ok = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            if (txd !== 1'b1) quiet_ok = 1'b0;
        end
        check("post_rst_txd_idle", quiet_ok, 1);
        check("post_rst_frames", frames_seen, seen);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_frames("after_rst_frames", seen + 1, 4000);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spart_echo_top.md
# spart_echo_top

Top level of the mini-SPART loopback design. Receives RS-232 frames (8N1) on `rxd` and retransmits each correctly framed byte unchanged on `txd`. Baud rate is selected by the `br_cfg` DIP switches. Internally it wires a programmable baud tick generator, a receiver, a transmitter and a small driver FSM that programs the divisor and echoes data.

## Interface
- No parameters. Divisor constants are listed under Structure.
- `clk` in 1 — 100 MHz system clock. Single clock domain.
- `rst` in 1 — reset. Synchronous, active-high.
- `txd` out 1 — serial transmit line. Idles high.
- `rxd` in 1 — serial receive line. Idles high and is asynchronous to `clk`.
- `br_cfg` in 2 — baud select: 00→divisor 0x12C0, 01→0x0960, 10→0x04B0, 11→0x0258.

## Operation
- **Baud generator** (ports `data[7:0]`, `sel_low`, `sel_high`, output `en`):
  - Holds a 16-bit divisor register, reset value 0x12C0.
  - `sel_low` writes `data` into bits [7:0]; `sel_high` writes bits [15:8]. If both are asserted, both halves get the same byte.
  - Down-counter runs from divisor−1 to 0. `en` is a 1-cycle pulse when the count is 0; the counter then reloads. Period = divisor clocks.
  - A divisor of 0 or 1 gives `en` every cycle.
  - Any write reloads the counter on the following cycle.
  - `en` is a 16× oversampling tick.
- **Receiver** (`RxD`, `Baud`, `RxD_data[7:0]`, `RDA`, `rd_rx`):
  - `RxD` passes through a 2-flop synchronizer.
  - States: IDLE → START → DATA → STOP.
  - IDLE: a low level starts START and clears the tick count.
  - START: at tick 8 the line is sampled. If it is still low, go to DATA; if high, it was a glitch, go back to IDLE.
  - DATA: one sample every 16 ticks, LSB first, 8 bits.
  - STOP: sampled 16 ticks after the last data bit.
    - High: latch `RxD_data` and set `RDA`.
    - Low: framing error; discard the byte, leave `RDA` unchanged, and return to IDLE only after the line is high.
  - `RDA` stays set until a cycle with `rd_rx`=1.
  - If a new byte completes while `RDA` is still set, it overwrites the data and `RDA` stays 1.
- **Transmitter** (`data[7:0]`, `en`, `en_tx`, `tbr`, `TxD`):
  - `en_tx` while `tbr`=1 loads the shift register and clears `tbr`. `en_tx` while busy is ignored.
  - The frame starts at the next `en` tick. Each bit lasts 16 ticks: start(0), d0..d7, stop(1).
  - `tbr` returns to 1 at the end of the stop bit.
- **Driver FSM**, states PROG_LO, PROG_HI, IDLE, ECHO:
  - After reset it writes the low byte of the `br_cfg` divisor, then the high byte on the next cycle, then enters IDLE.
  - In IDLE, if `br_cfg` differs from the last programmed value, it reprograms (PROG_LO).
  - In IDLE, when `RDA`=1 and `tbr`=1, it pulses `rd_rx` and `en_tx` for one cycle with the `RxD_data` byte, goes to ECHO, and returns to IDLE the next cycle.
  - A byte that arrives while the transmitter is busy waits in the receiver. It is dropped only if the next byte overwrites it.

## Timing
- Reset values:
  - `txd`=1, `tbr`=1, `RDA`=0, `RxD_data`=0, `en`=0.
  - Driver restarts at PROG_LO.
  - Reset mid-frame aborts both directions immediately, and `txd` goes high the cycle after reset is sampled.
- Divisor programming finishes 2 cycles after `rst` deasserts.
- `RDA` rises at stop-bit tick 8, i.e. about 152 ticks after the start-bit falling edge, ±1 tick of quantization plus 2 sync clocks.
- Echo start:
  - `rd_rx`/`en_tx` are asserted the cycle after `RDA` rises.
  - The `txd` start bit begins at the next `en` tick.
  - Echo latency ≈ 152–153 ticks after the incoming start edge.
- With br_cfg=00, one bit = 16×0x12C0 = 76 800 clocks, and one frame = 768 000 clocks.

## Structure
- Shared package `spart_pkg`:
  - divisor constants DIV_4800=16'h12C0, DIV_9600=16'h0960, DIV_19200=16'h04B0, DIV_38400=16'h0258;
  - `OVERSAMPLE`=16, `SAMPLE_PT`=8;
  - rx/tx and driver state enums.
- Sub-modules: `baud_rate_gen`, `rx`, `tx`. The externally visible sub-module interfaces must remain exactly as named in Operation. The top contains only wiring plus the driver FSM.

## Test plan
- **Basic echo:** br_cfg=00. An external 8N1 sender, using the same divisor 0x12C0 and 16× ticks, sends 0x40 into `rxd`. → `txd` emits one frame decoding to 0x40, and an external receiver's `RDA` rises exactly once.
- **Data patterns:** br_cfg=00, bytes 0x00, 0xFF, 0xA5 sent back to back. → three echoed frames in order with identical values and stop bits high.
- **Baud select:** br_cfg=11 with the sender at divisor 0x0258, byte 0x3C. → echoed 0x3C, bit period 9 600 clocks. Change br_cfg to 01 in IDLE → next `en` period 0x0960.
- **Glitch and framing errors:**
  - `rxd` pulsed low for 5 ticks → no `RDA`, `txd` stays high.
  - A frame with stop bit 0 → no echo. The next valid byte 0x55 is echoed.
- **Reset mid-operation:** assert `rst` during the echo's data bit 3. → `txd`=1 the next cycle, `tbr`=1, no further bits. After release, a new byte 0x81 echoes correctly.
